// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader
// Description : Byte-stream program loader that assembles address/data
//               records into instruction/data memory writes and hands the
//               memories to the core on RUN. Optional checksum byte per
//               record when BOOT_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_loader #(
    parameter int CLR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        ext_instr_we,
    output logic [15:0] ext_instr_addr,
    output logic [15:0] ext_instr_data,
    output logic        ext_data_write_en,
    output logic [15:0] ext_data_addr,
    output logic [15:0] ext_data_data,
    output logic        test_normal,
    output logic        clr,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR_H = 4'd1,
        S_ADDR_L = 4'd2,
        S_DATA_H = 4'd3,
        S_DATA_L = 4'd4,
        S_CHK    = 4'd5,
        S_WRITE  = 4'd6,
        S_CLR    = 4'd7,
        S_RUN    = 4'd8
    } state_t;

    localparam logic [7:0] c_hdr_instr = 8'hA5;
    localparam logic [7:0] c_hdr_data  = 8'h5A;
    localparam logic [7:0] c_hdr_run   = 8'hC3;
    localparam logic [7:0] c_hdr_halt  = 8'h3C;
    localparam logic [3:0] c_clr_load  = 4'(CLR_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_is_data;
    logic [15:0] r_asm_addr;
    logic [7:0]  r_data_hi;
    logic [3:0]  r_cnt;
    logic [15:0] r_out_addr;
    logic [15:0] r_out_data;
    logic        r_err;
    logic        w_accept;
    logic        w_set_err;
    logic        w_load_out;
    logic [15:0] w_word_data;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  r_data_lo;
    logic [7:0]  r_sum;
    logic [7:0]  w_sum_total;
    assign w_sum_total = r_sum + in_data;
    assign w_word_data = {r_data_hi, r_data_lo};
`else
    assign w_word_data = {r_data_hi, in_data};
`endif

    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_next     = r_state;
        w_set_err  = 1'b0;
        w_load_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (in_data)
                        c_hdr_instr, c_hdr_data: w_next = S_ADDR_H;
                        c_hdr_run:               w_next = S_CLR;
                        c_hdr_halt:              w_next = S_IDLE;
                        default:                 w_set_err = 1'b1;
                    endcase
                end
            end
            S_ADDR_H: if (w_accept) w_next = S_ADDR_L;
            S_ADDR_L: if (w_accept) w_next = S_DATA_H;
            S_DATA_H: if (w_accept) w_next = S_DATA_L;
            S_DATA_L: begin
                if (w_accept) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next     = S_WRITE;
                    w_load_out = 1'b1;
`endif
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) begin
                    if (w_sum_total == 8'h00) begin
                        w_next     = S_WRITE;
                        w_load_out = 1'b1;
                    end else begin
                        w_next    = S_IDLE;
                        w_set_err = 1'b1;
                    end
                end
            end
`endif
            S_WRITE: w_next = S_IDLE;
            S_CLR:   if (r_cnt == 4'd0) w_next = S_RUN;
            S_RUN: begin
                if (w_accept) begin
                    if (in_data == c_hdr_halt) w_next = S_IDLE;
                    else                       w_set_err = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_is_data  <= 1'b0;
            r_asm_addr <= 16'h0000;
            r_data_hi  <= 8'h00;
            r_cnt      <= 4'd0;
            r_out_addr <= 16'h0000;
            r_out_data <= 16'h0000;
            r_err      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_data_lo  <= 8'h00;
            r_sum      <= 8'h00;
`endif
        end else begin
            r_state <= w_next;
            if (w_set_err)  r_err <= 1'b1;
            if (w_load_out) begin
                r_out_addr <= r_asm_addr;
                r_out_data <= w_word_data;
            end
            if (r_state == S_CLR && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        r_is_data <= (in_data == c_hdr_data);
                        if (in_data == c_hdr_run) r_cnt <= c_clr_load;
                    end
                    S_ADDR_H: r_asm_addr[15:8] <= in_data;
                    S_ADDR_L: r_asm_addr[7:0]  <= in_data;
                    S_DATA_H: r_data_hi        <= in_data;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    S_DATA_L: r_data_lo        <= in_data;
`endif
                    default: ;
                endcase
`ifdef BOOT_LOADER_CHECKSUM_EN
                // Running sum restarts on every header so stray IDLE bytes never leak in.
                r_sum <= (r_state == S_IDLE) ? in_data : w_sum_total;
`endif
            end
        end
    end

    assign in_ready          = !(r_state == S_WRITE || r_state == S_CLR);
    assign ext_instr_we      = (r_state == S_WRITE) && !r_is_data;
    assign ext_data_write_en = (r_state == S_WRITE) &&  r_is_data;
    assign ext_instr_addr    = r_out_addr;
    assign ext_instr_data    = r_out_data;
    assign ext_data_addr     = r_out_addr;
    assign ext_data_data     = r_out_data;
    assign clr               = (r_state == S_CLR);
    assign test_normal       = !(r_state == S_CLR || r_state == S_RUN);
    assign busy              = !(r_state == S_IDLE || r_state == S_RUN);
    assign err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader
// Description : Self-checking bench for boot_loader: table of records with a
//               write scoreboard, plus RUN/HALT, error and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        ext_instr_we;
    logic [15:0] ext_instr_addr;
    logic [15:0] ext_instr_data;
    logic        ext_data_write_en;
    logic [15:0] ext_data_addr;
    logic [15:0] ext_data_data;
    logic        test_normal;
    logic        clr;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_data;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        exp_is_data;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[5];

    boot_loader #(.CLR_CYCLES(2)) dut (
        .clk               (clk),
        .clr_n             (clr_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .ext_instr_we      (ext_instr_we),
        .ext_instr_addr    (ext_instr_addr),
        .ext_instr_data    (ext_instr_data),
        .ext_data_write_en (ext_data_write_en),
        .ext_data_addr     (ext_data_addr),
        .ext_data_data     (ext_data_data),
        .test_normal       (test_normal),
        .clr               (clr),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write scoreboard: every strobe cycle must match the oldest pending write.
    always @(negedge clk) begin
        if (clr_n && (ext_instr_we || ext_data_write_en)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: instr_we=%0b data_we=%0b addr=%0h", ext_instr_we, ext_data_write_en, ext_instr_addr);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("strobe_kind", {30'd0, ext_instr_we, ext_data_write_en}, e.is_data ? 32'd1 : 32'd2);
                chk("instr_addr", {16'd0, ext_instr_addr}, {16'd0, e.addr});
                chk("instr_data", {16'd0, ext_instr_data}, {16'd0, e.data});
                chk("data_addr",  {16'd0, ext_data_addr},  {16'd0, e.addr});
                chk("data_data",  {16'd0, ext_data_data},  {16'd0, e.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_record(input logic [7:0] hdr, input logic [15:0] addr,
                               input logic [15:0] data, input logic expect_write);
        logic [7:0] sum;
        wr_t e;
        e.is_data = (hdr == 8'h5A);
        e.addr    = addr;
        e.data    = data;
        if (expect_write) sb.push_back(e);
        sum = hdr + addr[15:8] + addr[7:0] + data[15:8] + data[7:0];
        send_byte(hdr);        gap();
        send_byte(addr[15:8]); gap();
        send_byte(addr[7:0]);  gap();
        send_byte(data[15:8]); gap();
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(data[7:0]);  gap();
        send_byte(8'h00 - sum);
`else
        send_byte(data[7:0]);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},    {31'd0, in_ready}, 32'd1);
        chk({tag, "_instr_we"},    {31'd0, ext_instr_we}, 32'd0);
        chk({tag, "_data_we"},     {31'd0, ext_data_write_en}, 32'd0);
        chk({tag, "_addr"},        {16'd0, ext_instr_addr}, 32'd0);
        chk({tag, "_data"},        {16'd0, ext_instr_data}, 32'd0);
        chk({tag, "_daddr"},       {16'd0, ext_data_addr}, 32'd0);
        chk({tag, "_ddata"},       {16'd0, ext_data_data}, 32'd0);
        chk({tag, "_test_normal"}, {31'd0, test_normal}, 32'd1);
        chk({tag, "_clr"},         {31'd0, clr}, 32'd0);
        chk({tag, "_busy"},        {31'd0, busy}, 32'd0);
        chk({tag, "_err"},         {31'd0, err}, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{8'hA5, 16'h0000, 16'h1800, 1'b0};
        vecs[1] = '{8'h5A, 16'h0001, 16'h4321, 1'b1};
        vecs[2] = '{8'hA5, 16'hFFFF, 16'hABCD, 1'b0};
        vecs[3] = '{8'h5A, 16'h8000, 16'h00FF, 1'b1};
        vecs[4] = '{8'hA5, 16'h1234, 16'h5678, 1'b0};

        #12;
        check_reset_values("rst");
        clr_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            send_record(vecs[i].hdr, vecs[i].addr, vecs[i].data, 1'b1);
            chk("write_ready", {31'd0, in_ready}, 32'd0);
            chk("write_busy",  {31'd0, busy}, 32'd1);
            chk("write_err",   {31'd0, err}, 32'd0);
            @(posedge clk); #1;
            chk("post_write_kept_addr", {16'd0, ext_instr_addr}, {16'd0, vecs[i].addr});
            chk("post_write_busy", {31'd0, busy}, 32'd0);
        end

        // RUN then HALT
        send_byte(8'hC3);
        chk("clr_rise", {31'd0, clr}, 32'd1);
        chk("tn_fall",  {31'd0, test_normal}, 32'd0);
        chk("clr_ready", {31'd0, in_ready}, 32'd0);
        n = 1;
        for (int k = 0; k < 20 && clr; k++) begin
            @(posedge clk); #1;
            if (clr) n++;
        end
        chk("clr_cycles", n, 32'd2);
        chk("run_tn",    {31'd0, test_normal}, 32'd0);
        chk("run_ready", {31'd0, in_ready}, 32'd1);
        chk("run_busy",  {31'd0, busy}, 32'd0);
        send_byte(8'h3C);
        chk("halt_tn", {31'd0, test_normal}, 32'd1);

        // Bad header in IDLE, then a record still writes
        send_byte(8'h77);
        chk("bad_hdr_err",  {31'd0, err}, 32'd1);
        chk("bad_hdr_busy", {31'd0, busy}, 32'd0);
        send_record(8'hA5, 16'h0042, 16'hBEEF, 1'b1);
        @(posedge clk); #1;
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset mid-record
        send_byte(8'hA5);
        send_byte(8'h00);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        clr_n = 1'b0;
        #2;
        check_reset_values("async");
        @(posedge clk); #1;
        clr_n = 1'b1;
        @(posedge clk); #1;
        send_record(8'hA5, 16'h0008, 16'hE040, 1'b1);
        @(posedge clk); #1;
        chk("after_rst_data", {16'd0, ext_instr_data}, 32'h0000E040);

`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("bad_sum_err",  {31'd0, err}, 32'd1);
        chk("bad_sum_busy", {31'd0, busy}, 32'd0);
`endif

        // Stray byte while running is consumed and flagged
        clr_n = 1'b0; #2; clr_n = 1'b1;
        @(posedge clk); #1;
        send_byte(8'hC3);
        repeat (3) begin @(posedge clk); #1; end
        send_byte(8'h11);
        chk("run_bad_err", {31'd0, err}, 32'd1);
        chk("run_bad_tn",  {31'd0, test_normal}, 32'd0);
        send_byte(8'h3C);
        chk("run_bad_halt_tn", {31'd0, test_normal}, 32'd1);

        repeat (4) begin @(posedge clk); #1; end
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
